io_bus_master: RTL and testbench



---
 rtl/io_bus_master.sv | 70 +++++++
 tb/tb_io_bus_master.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/io_bus_master.sv
// io_bus_master: sequences single core requests onto the I/O bus with setup then one-cycle strobe
module io_bus_master #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 4,
  parameter int SETUP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_write_en,
  output logic              bus_read_en
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  localparam logic [2:0] CNT_INIT = 3'(SETUP_CYCLES - 1);
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic we, accept;
  assign req_ready = state == IDLE;
  assign accept = req_ready && req_valid;
  // next-state and setup counter: counter expiry in SETUP moves to the strobe cycle
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    state_nx = state == IDLE   ? (req_valid ? SETUP : IDLE) :
               state == SETUP  ? (cnt == 3'd0 ? ACCESS : SETUP) :
               state == ACCESS ? DONE : IDLE;
    cnt_nx = accept ? CNT_INIT : (state == SETUP && cnt != 3'd0) ? cnt - 3'd1 : cnt;
  end
  // state register and setup counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 3'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // bus outputs registered from next state so strobes are glitch-free and reset clears them at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_write_en <= 1'b0;
      bus_read_en <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        we <= req_we;
        bus_addr <= req_addr;
        bus_wdata <= req_wdata;
      end
      bus_write_en <= state_nx == ACCESS && we;
      bus_read_en <= state_nx == ACCESS && !we;
      resp_valid <= state_nx == DONE;
      if (state == ACCESS && !we) resp_rdata <= bus_rdata;
    end
  end
endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: table-driven and scoreboard checks of io_bus_master at SETUP_CYCLES 1 and 3
module tb_io_bus_master;
  logic clk = 1'b0, reset = 1'b1;
  logic rv1 = 1'b0, rv3 = 1'b0, req_we = 1'b0, s3 = 1'b0;
  logic [10:0] req_addr = '0;
  logic [3:0] req_wdata = '0, bus_rdata = 4'hF;
  logic rdy1, rdy3, rsp1, rsp3, we1, we3, re1, re3;
  logic [3:0] rd1, rd3, wd1, wd3;
  logic [10:0] ad1, ad3;
  logic o_ready, o_resp_valid, o_we_en, o_re_en;
  logic [3:0] o_resp_rdata, o_bus_wdata;
  logic [10:0] o_bus_addr;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [3:0] sb[$];
  typedef struct {
    logic we;
    logic [10:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
    logic [3:0] exp_rd;
    logic s3;
  } vec_t;
  vec_t tbl[6];

  io_bus_master #(.SETUP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rsp1), .resp_rdata(rd1),
    .bus_addr(ad1), .bus_wdata(wd1), .bus_rdata(bus_rdata), .bus_write_en(we1), .bus_read_en(re1));

  io_bus_master #(.SETUP_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rsp3), .resp_rdata(rd3),
    .bus_addr(ad3), .bus_wdata(wd3), .bus_rdata(bus_rdata), .bus_write_en(we3), .bus_read_en(re3));

  assign o_ready = s3 ? rdy3 : rdy1;
  assign o_resp_valid = s3 ? rsp3 : rsp1;
  assign o_resp_rdata = s3 ? rd3 : rd1;
  assign o_bus_addr = s3 ? ad3 : ad1;
  assign o_bus_wdata = s3 ? wd3 : wd1;
  assign o_we_en = s3 ? we3 : we1;
  assign o_re_en = s3 ? re3 : re1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every response must match the oldest pending expectation; strobes never overlap
  always @(negedge clk) begin
    if (o_we_en || o_re_en) chk("strobe_exclusive", o_we_en & o_re_en, 0);
    if (o_resp_valid) begin
      if (sb.size() == 0) chk("unexpected_resp", 1, 0);
      else chk("resp_rdata", o_resp_rdata, sb.pop_front());
    end
  end

  task automatic wait_rdy();
    int n = 0;
    @(negedge clk);
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", o_ready, 1);
  endtask

  task automatic run(input vec_t v);
    int s;
    s3 = v.s3;
    s = v.s3 ? 3 : 1;
    wait_rdy();
    req_we = v.we;
    req_addr = v.addr;
    req_wdata = v.wdata;
    bus_rdata = 4'hF;
    if (v.s3) rv3 = 1'b1; else rv1 = 1'b1;
    sb.push_back(v.exp_rd);
    for (int k = 1; k <= s + 3; k++) begin
      @(negedge clk);
      rv1 = 1'b0;
      rv3 = 1'b0;
      chk("write_en", o_we_en, (k == s + 1) && v.we);
      chk("read_en", o_re_en, (k == s + 1) && !v.we);
      chk("resp_valid", o_resp_valid, k == s + 2);
      chk("req_ready", o_ready, k == s + 3);
      chk("bus_addr", o_bus_addr, v.addr);
      if (v.we) chk("bus_wdata", o_bus_wdata, v.wdata);
      bus_rdata = (k == s + 1) ? v.rdata : 4'hF;
    end
  endtask

  initial begin
    int t1, t2, n;
    tbl[0] = '{1'b1, 11'h7FF, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[1] = '{1'b0, 11'h7FE, 4'h0, 4'h5, 4'h5, 1'b0};
    tbl[2] = '{1'b1, 11'h001, 4'h3, 4'h0, 4'h5, 1'b0};
    tbl[3] = '{1'b0, 11'h400, 4'h0, 4'hC, 4'hC, 1'b0};
    tbl[4] = '{1'b0, 11'h7FE, 4'h0, 4'h5, 4'h5, 1'b1};
    tbl[5] = '{1'b1, 11'h2AA, 4'h6, 4'h0, 4'h5, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_rdata", o_resp_rdata, 0);
    chk("rst_bus_addr", o_bus_addr, 0);
    chk("rst_bus_wdata", o_bus_wdata, 0);
    chk("rst_enables", {o_we_en, o_re_en}, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) if (!tbl[i].s3) run(tbl[i]);
    s3 = 1'b0;
    wait_rdy();
    req_we = 1'b1;
    req_addr = 11'h111;
    req_wdata = 4'h9;
    bus_rdata = 4'h7;
    rv1 = 1'b1;
    sb.push_back(4'hC);
    t1 = cyc;
    @(negedge clk);
    req_we = 1'b0;
    req_addr = 11'h222;
    sb.push_back(4'h7);
    n = 0;
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    chk("b2b_spacing", t2 - t1, 4);
    @(negedge clk);
    rv1 = 1'b0;
    wait_rdy();
    @(negedge clk);
    chk("b2b_drain", sb.size(), 0);
    wait_rdy();
    req_we = 1'b1;
    req_addr = 11'h050;
    req_wdata = 4'h2;
    bus_rdata = 4'hF;
    rv1 = 1'b1;
    sb.push_back(4'h7);
    @(negedge clk);
    req_addr = 11'h123;
    @(negedge clk);
    rv1 = 1'b0;
    req_addr = 11'h050;
    for (int k = 0; k < 6; k++) begin
      chk("busy_addr_not_taken", o_bus_addr == 11'h123, 0);
      @(negedge clk);
    end
    chk("busy_drain", sb.size(), 0);
    chk("busy_idle", o_ready, 1);
    wait_rdy();
    req_we = 1'b1;
    req_addr = 11'h321;
    req_wdata = 4'h5;
    rv1 = 1'b1;
    @(negedge clk);
    rv1 = 1'b0;
    @(negedge clk);
    chk("rst_pre_strobe", o_we_en, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_enables", {o_we_en, o_re_en}, 0);
    chk("rst_mid_ready", o_ready, 1);
    chk("rst_mid_resp_valid", o_resp_valid, 0);
    chk("rst_mid_resp_rdata", o_resp_rdata, 0);
    chk("rst_mid_bus_addr", o_bus_addr, 0);
    chk("rst_mid_bus_wdata", o_bus_wdata, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_after_ready", o_ready, 1);
    end
    for (int i = 0; i < 6; i++) if (tbl[i].s3) run(tbl[i]);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
